// File: rtl/ft_basic_read.sv
// FT600 245-mode synchronous-FIFO read master.
// Pulls host-to-FPGA words off the FT bus into a small FWFT buffer, presents
// them as a valid/ready stream, and checks them against an incrementing
// 16-bit counting pattern. The word and error counters drive the status LEDs.
module ft_basic_read #(
  parameter int FIFO_DEPTH = 8,
  parameter int HEADROOM   = 2
) (
  input  logic        ft_clk,
  input  logic        rst_n,
  input  logic        ft_rxf_n,
  input  logic [15:0] ft_data,
  input  logic [1:0]  ft_be,
  output logic        ft_oe_n,
  output logic        ft_rd_n,
  output logic [15:0] m_data,
  output logic [1:0]  m_be,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] word_count,
  output logic [15:0] err_count,
  output logic        pattern_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] STOP_LEVEL = LW'(FIFO_DEPTH - HEADROOM);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    OE,
    READ
  } state_t;

  state_t state, state_next;

  logic [17:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] level, level_next;
  logic [15:0]   exp_word;
  logic          cap, pop;

  // A word is on the bus and being strobed whenever we sit in READ with data available.
  assign cap     = (state == READ) && !ft_rxf_n;
  assign m_valid = (level != '0);
  assign pop     = m_valid && m_ready;

  // Head entry is shown only while valid so the stream reads zero when empty.
  assign {m_be, m_data} = m_valid ? mem[rd_ptr] : 18'd0;

  // Occupancy after this edge, used to end a burst before the buffer can fill.
  always_comb begin
    level_next = level + {{(LW-1){1'b0}}, cap} - {{(LW-1){1'b0}}, pop};
  end

  // Next-state decode for the bus handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!ft_rxf_n && (level < STOP_LEVEL)) state_next = OE;
      OE:   state_next = ft_rxf_n ? IDLE : READ;
      READ: if (ft_rxf_n || (level_next >= STOP_LEVEL)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register; strobes are registered from the next state so they track it exactly.
  always_ff @(posedge ft_clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ft_oe_n <= 1'b1;
      ft_rd_n <= 1'b1;
    end else begin
      state   <= state_next;
      ft_oe_n <= (state_next == IDLE);
      ft_rd_n <= (state_next != READ);
    end
  end

  // Buffer storage; contents need no reset because level gates visibility.
  always_ff @(posedge ft_clk) begin
    if (cap) mem[wr_ptr] <= {ft_be, ft_data};
  end

  // Buffer pointers and occupancy; reset discards anything buffered.
  always_ff @(posedge ft_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (cap) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level_next;
    end
  end

  // Pattern checker and counters; exp always resyncs to the received word plus one.
  always_ff @(posedge ft_clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_word    <= '0;
      word_count  <= '0;
      err_count   <= '0;
      pattern_err <= 1'b0;
    end else if (cap) begin
      word_count <= word_count + 32'd1;
      exp_word   <= ft_data + 16'd1;
      if (ft_data != exp_word) begin
        pattern_err <= 1'b1;
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      end
    end
  end

  a_no_overflow: assert property (@(posedge ft_clk) disable iff (!rst_n)
    !(cap && (level == FULL_LEVEL)));

endmodule

// File: doc/ft_basic_read.md
Name: ft_basic_read

Overview:
- FT600 245-mode synchronous-FIFO read master: moves host-to-FPGA data off the FT bus into a small first-word-fall-through (FWFT) buffer and presents it as a valid/ready stream.
- It is the receive-side counterpart of the basic write path.
- It also checks that incoming words form an incrementing 16-bit counting pattern and keeps word and error counters for LED/status display.
- Runs entirely in the FT clock domain; the top level owns the bidirectional tristate and feeds this block the input side of ft_data/ft_be.

Parameters:
- FIFO_DEPTH, 8: buffer depth in words; power of two, at least 4.
- HEADROOM, 2: free-slot margin; a burst stops when the buffer level reaches FIFO_DEPTH-HEADROOM. Range 1..FIFO_DEPTH-2.

Ports:
- ft_clk  in  1  FT600 interface clock, the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ft_rxf_n  in  1  FT600 RX-not-empty, low = data available.
- ft_data  in  16  FT600 data bus, input side.
- ft_be  in  2  FT600 byte enables, input side.
- ft_oe_n  out  1  FT600 output enable, low = FT600 drives the bus.
- ft_rd_n  out  1  FT600 read strobe, low = read.
- m_data  out  16  stream data.
- m_be  out  2  stream byte enables.
- m_valid  out  1  stream valid.
- m_ready  in  1  stream ready.
- word_count  out  32  words captured since reset.
- err_count  out  16  pattern mismatches since reset.
- pattern_err  out  1  sticky mismatch flag.

Behaviour:
- Interface decided: one clock, ft_clk; reset rst_n, asynchronous, active-low.
- Reset values: ft_oe_n=1, ft_rd_n=1, m_valid=0, m_data=0, m_be=0, word_count=0, err_count=0, pattern_err=0. FIFO empty, expected-pattern register exp=0, state IDLE.
- Reset mid-operation: all of the above take effect immediately, without waiting for a clock edge. Any words in the buffer are discarded.
- ft_oe_n and ft_rd_n are registered outputs decoded from the state, with no combinational path from inputs.
- States:
  - IDLE: oe_n=1, rd_n=1. Go to OE when ft_rxf_n=0 and level < FIFO_DEPTH-HEADROOM.
  - OE: oe_n=0, rd_n=1, for exactly one cycle (bus turnaround). Go to READ if ft_rxf_n=0, else go to IDLE.
  - READ: oe_n=0, rd_n=0. Go to IDLE when ft_rxf_n=1, or when level_next >= FIFO_DEPTH-HEADROOM.
- Capture: cap = (state==READ) && ft_rxf_n==0, sampled at the rising edge. The word {ft_be, ft_data} is pushed on that edge. Because leaving READ is decided on the same edge and the strobes are registered, no word is ever presented while the buffer is full. Overflow is therefore impossible by construction, and a push into a full buffer is an assertion failure.
- level_next = level + cap - pop.
- FIFO is FWFT:
  - m_valid = not empty; m_data/m_be show the head entry.
  - pop = m_valid && m_ready.
  - Push and pop on the same edge leave level unchanged.
  - Push into an empty FIFO: m_valid rises on the edge after the capture edge (1-cycle latency).
  - m_data/m_be stay stable while m_valid=1 and m_ready=0.
- Pattern check, on each cap:
  - If ft_data != exp: err_count increments (saturates at 16'hFFFF) and pattern_err is set, staying set until reset.
  - In all cases, exp <= ft_data+1, wrapping modulo 2^16, so the checker resyncs after an error.
- word_count increments on each cap and wraps modulo 2^32.
- Byte enables are passed through unchecked. Partial words (ft_be != 2'b11) are still counted and pattern-checked on all 16 bits.

Test Plan:
1. Hold rst_n=0 with ft_rxf_n=0 toggling -> ft_oe_n=1, ft_rd_n=1, m_valid=0, both counts 0 throughout.
2. Host model queues 0,1,2,3 with m_ready=1 -> ft_oe_n falls 1 cycle after ft_rxf_n seen low, ft_rd_n falls 1 cycle later, 4 captures. Both strobes return high on the edge after ft_rxf_n=1 is sampled. Stream carries 0,1,2,3 in order; word_count=4, err_count=0.
3. Defaults, host queues 20 words 0..19, m_ready=0 -> exactly 6 captured, then ft_rd_n=1 and ft_oe_n=1, m_valid=1 with m_data=0. Release m_ready=1 -> bursts resume; all 20 words delivered in order, no loss or duplicates, word_count=20.
4. Host sends 0,1,2,7,8 -> err_count=1, pattern_err=1, no error on 8, word_count=5.
5. Host sends 16'hFFFE, 16'hFFFF, 16'h0000 from reset -> first word mismatches exp=0, wrap to 0 accepted; err_count=1.
6. Assert rst_n=0 mid-burst with ft_rd_n=0 and 3 words buffered -> ft_rd_n=1, ft_oe_n=1, m_valid=0 immediately. After release, next word 0 produces no error (exp=0).
